pipelined_adder: RTL and testbench

// - Parametrised, pipelined two's-complement adder; generalises the 4-bit adder to WIDTH bits.
// - Carry chain is split into WIDTH/LANE registered stages, so the clock rate is set by a LANE-bit add, not a WIDTH-bit add.
// - valid/ready streaming interface on both sides, so it drops into datapaths that can stall.

---
 rtl/pipelined_adder.sv | 124 ++++++++++++
 tb/tb_pipelined_adder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit two's-complement adder, LANE bits of carry chain per stage, valid/ready on both sides.
// Define ADDER_SAT_EN to saturate the sum on signed overflow instead of wrapping.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int LANE  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / LANE;

    if ((WIDTH % LANE) != 0 || STAGES < 1) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a non-zero multiple of LANE");
    end

    logic             adv;
    logic [WIDTH-1:0] raw_sum;
    logic             sign_a;
    logic             sign_b;

    // The whole pipe moves in lockstep; bubbles are never squeezed out.
    assign out_valid = g_stage[STAGES-1].valid_q;
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO  = gi * LANE;
        localparam int REM = WIDTH - LO - LANE;

        logic                valid_in;
        logic                carry_in;
        logic [WIDTH-LO-1:0] ops_a;
        logic [WIDTH-LO-1:0] ops_b;
        logic [LANE:0]       lane_sum;
        logic [LO+LANE-1:0]  sum_d;
        logic                valid_q;
        logic                carry_q;
        logic [LO+LANE-1:0]  sum_q;

        // ops_a/ops_b hold only the operand bits from this lane upwards.
        if (gi == 0) begin : g_first
            assign valid_in = in_valid;
            assign carry_in = cin;
            assign ops_a    = a;
            assign ops_b    = b;
            assign sum_d    = lane_sum[LANE-1:0];
        end else begin : g_next
            assign valid_in = g_stage[gi-1].valid_q;
            assign carry_in = g_stage[gi-1].carry_q;
            assign ops_a    = g_stage[gi-1].g_fwd.a_q;
            assign ops_b    = g_stage[gi-1].g_fwd.b_q;
            assign sum_d    = {lane_sum[LANE-1:0], g_stage[gi-1].sum_q};
        end

        assign lane_sum = (LANE+1)'(ops_a[LANE-1:0]) + (LANE+1)'(ops_b[LANE-1:0])
                        + (LANE+1)'(carry_in);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (adv) begin
                valid_q <= valid_in;
                carry_q <= lane_sum[LANE];
                sum_q   <= sum_d;
            end
        end

        if (REM > 0) begin : g_fwd
            logic [REM-1:0] a_q;
            logic [REM-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= ops_a[WIDTH-LO-1:LANE];
                    b_q <= ops_b[WIDTH-LO-1:LANE];
                end
            end
        end else begin : g_last
            // Only the operand sign bits survive into the output stage, for overflow.
            logic sign_a_q;
            logic sign_b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sign_a_q <= 1'b0;
                    sign_b_q <= 1'b0;
                end else if (adv) begin
                    sign_a_q <= ops_a[LANE-1];
                    sign_b_q <= ops_b[LANE-1];
                end
            end
        end
    end

    assign raw_sum = g_stage[STAGES-1].sum_q;
    assign sign_a  = g_stage[STAGES-1].g_last.sign_a_q;
    assign sign_b  = g_stage[STAGES-1].g_last.sign_b_q;
    assign cout    = g_stage[STAGES-1].carry_q;
    assign ovf     = (sign_a == sign_b) & (raw_sum[WIDTH-1] != sign_a);

`ifdef ADDER_SAT_EN
    assign sum = !ovf  ? raw_sum :
                 sign_a ? {1'b1, {(WIDTH-1){1'b0}}} :
                          {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign sum = raw_sum;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench for pipelined_adder (WIDTH=16, LANE=4), wrap or saturating build.
module tb_pipelined_adder;
`ifdef ADDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(16), .LANE(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Reference: {cout, ovf, sum} from a plain 17-bit addition.
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] full;
        logic        v;
        logic [15:0] s;
        full = {1'b0, x} + {1'b0, y} + 17'(c);
        v    = (x[15] == y[15]) && (full[15] != x[15]);
        s    = full[15:0];
        if (SAT && v) s = x[15] ? 16'h8000 : 16'h7FFF;
        return {full[16], v, s};
    endfunction

    // Presents one operation, then waits for its result; lat = -1 on timeout.
    task automatic send_op(input logic [15:0] x, input logic [15:0] y, input logic c,
                           output int lat, output logic [15:0] s, output logic co,
                           output logic ov, output logic rdy);
        @(negedge clk);
        a = x; b = y; cin = c; in_valid = 1'b1;
        #1 rdy = in_ready;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
        s = sum; co = cout; ov = ovf;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_hold_valid got=%b exp=0", out_valid); end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests_run++;
        if (sum !== 16'h0000) begin tests_failed++; $display("FAIL reset_sum got=%h exp=0000", sum); end
        tests_run++;
        if (cout !== 1'b0) begin tests_failed++; $display("FAIL reset_cout got=%b exp=0", cout); end
        tests_run++;
        if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        $display("[TB] reset: out_valid=%b sum=%h in_ready=%b", out_valid, sum, in_ready);
    endtask

    task automatic test_basic();
        int lat; logic [15:0] s; logic co, ov, rdy;
        send_op(16'h1234, 16'h1111, 1'b0, lat, s, co, ov, rdy);
        $display("[TB] 1234+1111+0 -> sum=%h cout=%b ovf=%b lat=%0d", s, co, ov, lat);
        tests_run++;
        if (rdy !== 1'b1) begin tests_failed++; $display("FAIL basic_in_ready got=%b exp=1", rdy); end
        tests_run++;
        if (lat != 4) begin tests_failed++; $display("FAIL basic_latency got=%0d exp=4", lat); end
        tests_run++;
        if (s !== 16'h2345) begin tests_failed++; $display("FAIL basic_sum got=%h exp=2345", s); end
        tests_run++;
        if ({co, ov} !== 2'b00) begin tests_failed++; $display("FAIL basic_flags got=%b%b exp=00", co, ov); end
    endtask

    task automatic test_carry();
        int lat; logic [15:0] s; logic co, ov, rdy;
        send_op(16'hFFFF, 16'h0001, 1'b0, lat, s, co, ov, rdy);
        $display("[TB] FFFF+0001+0 -> sum=%h cout=%b ovf=%b lat=%0d", s, co, ov, lat);
        tests_run++;
        if (s !== 16'h0000) begin tests_failed++; $display("FAIL carry_chain_sum got=%h exp=0000", s); end
        tests_run++;
        if ({co, ov} !== 2'b10) begin tests_failed++; $display("FAIL carry_chain_flags got=%b%b exp=10", co, ov); end
        tests_run++;
        if (lat != 4) begin tests_failed++; $display("FAIL carry_chain_latency got=%0d exp=4", lat); end
        send_op(16'h000F, 16'h0000, 1'b1, lat, s, co, ov, rdy);
        $display("[TB] 000F+0000+1 -> sum=%h cout=%b ovf=%b lat=%0d", s, co, ov, lat);
        tests_run++;
        if (s !== 16'h0010) begin tests_failed++; $display("FAIL cin_sum got=%h exp=0010", s); end
        tests_run++;
        if ({co, ov} !== 2'b00) begin tests_failed++; $display("FAIL cin_flags got=%b%b exp=00", co, ov); end
    endtask

    task automatic test_overflow();
        int lat; logic [15:0] s; logic co, ov, rdy;
        logic [15:0] exp_pos, exp_neg;
        exp_pos = SAT ? 16'h7FFF : 16'h8000;
        exp_neg = SAT ? 16'h8000 : 16'h7FFF;
        send_op(16'h7FFF, 16'h0001, 1'b0, lat, s, co, ov, rdy);
        $display("[TB] 7FFF+0001+0 -> sum=%h cout=%b ovf=%b lat=%0d", s, co, ov, lat);
        tests_run++;
        if (s !== exp_pos) begin tests_failed++; $display("FAIL ovf_pos_sum got=%h exp=%h", s, exp_pos); end
        tests_run++;
        if ({co, ov} !== 2'b01) begin tests_failed++; $display("FAIL ovf_pos_flags got=%b%b exp=01", co, ov); end
        send_op(16'h8000, 16'hFFFF, 1'b0, lat, s, co, ov, rdy);
        $display("[TB] 8000+FFFF+0 -> sum=%h cout=%b ovf=%b lat=%0d", s, co, ov, lat);
        tests_run++;
        if (s !== exp_neg) begin tests_failed++; $display("FAIL ovf_neg_sum got=%h exp=%h", s, exp_neg); end
        tests_run++;
        if ({co, ov} !== 2'b11) begin tests_failed++; $display("FAIL ovf_neg_flags got=%b%b exp=11", co, ov); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [8] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0F0F, 16'hABCD, 16'h0000, 16'h8000};
        logic [15:0] vb [8] = '{16'h1111, 16'h0001, 16'h0001, 16'hFFFF, 16'hF0F0, 16'h1234, 16'h0000, 16'h8000};
        logic        vc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [17:0] expq[$];
        int sent = 0, got = 0, stall_seen = 0, cyc = 0;
        @(negedge clk);
        while (got < 8 && cyc < 100) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid  = (sent < 8);
            if (sent < 8) begin a = va[sent]; b = vb[sent]; cin = vc[sent]; end
            #1;
            if (out_valid) begin
                tests_run++;
                if (expq.size() == 0) begin
                    tests_failed++;
                    $display("FAIL b2b_unexpected got sum=%h exp=no result", sum);
                end else begin
                    if ({cout, ovf, sum} !== expq[0]) begin
                        tests_failed++;
                        $display("FAIL b2b_result got=%b_%b_%h exp=%b_%b_%h",
                                 cout, ovf, sum, expq[0][17], expq[0][16], expq[0][15:0]);
                    end
                    if (out_ready) begin
                        $display("[TB] b2b result %0d: sum=%h cout=%b ovf=%b", got, sum, cout, ovf);
                        void'(expq.pop_front());
                        got++;
                    end else begin
                        stall_seen++;
                        tests_run++;
                        if (in_ready !== 1'b0) begin
                            tests_failed++;
                            $display("FAIL b2b_stall_in_ready got=%b exp=0", in_ready);
                        end
                    end
                end
            end
            if (in_valid && in_ready) begin
                expq.push_back(model(a, b, cin));
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tests_run++;
        if (got != 8) begin tests_failed++; $display("FAIL b2b_count got=%0d exp=8", got); end
        tests_run++;
        if (stall_seen != 3) begin tests_failed++; $display("FAIL b2b_stall_cycles got=%0d exp=3", stall_seen); end
    endtask

    task automatic test_reset_midflight();
        int lat, stale; logic [15:0] s; logic co, ov, rdy;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 16'h0100 * 16'(i + 1); b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL midrst_pre_valid got=%b exp=1", out_valid); end
        rst_n = 1'b0;
        #1;
        $display("[TB] mid-flight reset asserted: out_valid=%b sum=%h", out_valid, sum);
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        tests_run++;
        if (sum !== 16'h0000) begin tests_failed++; $display("FAIL midrst_sum got=%h exp=0000", sum); end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        tests_run++;
        if (stale != 0) begin tests_failed++; $display("FAIL midrst_stale got=%0d exp=0", stale); end
        send_op(16'h0102, 16'h0304, 1'b0, lat, s, co, ov, rdy);
        $display("[TB] post-reset 0102+0304+0 -> sum=%h lat=%0d", s, lat);
        tests_run++;
        if (lat != 4) begin tests_failed++; $display("FAIL midrst_latency got=%0d exp=4", lat); end
        tests_run++;
        if (s !== 16'h0406) begin tests_failed++; $display("FAIL midrst_sum_after got=%h exp=0406", s); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_overflow();
        test_back_to_back();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
